// File: rtl/pool_flatten_engine.sv
// 2x2 max-pool engine: reads layer-0 maps, writes pooled layer-1 maps and the interleaved flatten.
// Build option POOL_CEIL_EN rounds each pooled value up to the next integer (fixed point).
module pool_flatten_engine #(
  parameter int DW        = 20,
  parameter int FRAC_BITS = 16,
  parameter int IMG_LOG2  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  crd,
  output logic [2*IMG_LOG2-1:0] caddr_rd,
  input  logic [DW-1:0]         cdata_rd,
  output logic                  cwr,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic [DW-1:0]         cdata_wr,
  output logic [2:0]            csel
);

  localparam int PW = IMG_LOG2 - 1;
  localparam int IW = 2 * PW;
  localparam logic [IW-1:0] IDX_LAST = '1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WL1  = 3'd3;
  localparam logic [2:0] S_WL2  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state, state_n;
  logic [1:0]    sub, sub_n;
  logic [IW-1:0] idx, idx_n;
  logic          k, k_n;
  logic [DW-1:0] max_val, max_n, pooled;
  logic          rd_v, rd_first;

  // Read data lags its strobe by one cycle, so the running max folds in the previous read.
  always_comb begin
    max_n = max_val;
    if (rd_v && (rd_first || ($signed(cdata_rd) > $signed(max_val))))
      max_n = cdata_rd;
  end

`ifdef POOL_CEIL_EN
  localparam logic [DW-1:0] FRAC_MASK = {{(DW-FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}};
  localparam logic [DW-1:0] FRAC_ONE  = {{(DW-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};

  always_comb begin
    pooled = max_n;
    if (|(max_n & FRAC_MASK))
      pooled = (max_n & ~FRAC_MASK) + FRAC_ONE;
  end
`else
  assign pooled = max_n;
`endif

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    state_n = state;
    sub_n   = sub;
    idx_n   = idx;
    k_n     = k;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_RD;
        sub_n   = 2'd0;
        idx_n   = '0;
        k_n     = 1'b0;
      end
      S_RD: begin
        sub_n = sub + 2'd1;
        if (sub == 2'd3) state_n = S_CAP;
      end
      S_CAP: state_n = S_WL1;
      S_WL1: state_n = S_WL2;
      S_WL2: begin
        if (!k) begin
          k_n     = 1'b1;
          state_n = S_RD;
        end else if (idx != IDX_LAST) begin
          k_n     = 1'b0;
          idx_n   = idx + 1'b1;
          state_n = S_RD;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      sub      <= 2'd0;
      idx      <= '0;
      k        <= 1'b0;
      max_val  <= '0;
      rd_v     <= 1'b0;
      rd_first <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'd0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
    end else begin
      state    <= state_n;
      sub      <= sub_n;
      idx      <= idx_n;
      k        <= k_n;
      max_val  <= max_n;
      rd_v     <= crd;
      rd_first <= crd && (sub == 2'd0);
      busy     <= (state_n == S_RD) || (state_n == S_CAP) ||
                  (state_n == S_WL1) || (state_n == S_WL2);
      done     <= (state_n == S_DONE);
      crd      <= (state_n == S_RD);
      cwr      <= (state_n == S_WL1) || (state_n == S_WL2);
      case (state_n)
        S_RD, S_CAP: csel <= 3'd1 + {2'b00, k_n};
        S_WL1:       csel <= 3'd3 + {2'b00, k_n};
        S_WL2:       csel <= 3'd5;
        default:     csel <= 3'd0;
      endcase
      if (state_n == S_RD)
        caddr_rd <= {idx_n[IW-1:PW], sub_n[1], idx_n[PW-1:0], sub_n[0]};
      if (state_n == S_WL1) begin
        caddr_wr <= {2'b00, idx_n};
        cdata_wr <= pooled;
      end
      if (state_n == S_WL2)
        caddr_wr <= {1'b0, idx_n, k_n};
    end
  end

endmodule

// File: tb/tb_pool_flatten_engine.sv
// Directed bench for pool_flatten_engine with a behavioural layer-memory responder.
module tb_pool_flatten_engine;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] mem1 [4096];
  logic [DW-1:0] mem2 [4096];
  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] mem4 [1024];
  logic [DW-1:0] mem5 [2048];

  int l1_writes = 0, l2_writes = 0, l2_order_err = 0, bad_sel = 0;
  int both_cnt = 0, idle_strobe = 0, idle_csel = 0;
  logic [11:0] l2_expect = 12'd0;
  int total = 0, passes = 0, ncyc = 0;

  pool_flatten_engine dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  // Memory responder: read data appears the cycle after the strobe; writes land on the edge.
  always @(posedge clk) begin
    if (crd) cdata_rd <= (csel == 3'd1) ? mem1[caddr_rd] : mem2[caddr_rd];
    if (cwr) begin
      case (csel)
        3'd3: begin mem3[caddr_wr[9:0]] <= cdata_wr; l1_writes <= l1_writes + 1; end
        3'd4: begin mem4[caddr_wr[9:0]] <= cdata_wr; l1_writes <= l1_writes + 1; end
        3'd5: begin
          mem5[caddr_wr[10:0]] <= cdata_wr;
          l2_writes <= l2_writes + 1;
          if (caddr_wr != l2_expect) l2_order_err <= l2_order_err + 1;
          l2_expect <= (caddr_wr == 12'd2047) ? 12'd0 : caddr_wr + 12'd1;
        end
        default: bad_sel <= bad_sel + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (crd && cwr) both_cnt <= both_cnt + 1;
    if (!busy && (crd || cwr)) idle_strobe <= idle_strobe + 1;
    if (!busy && csel != 3'd0) idle_csel <= idle_csel + 1;
  end

  function automatic logic [DW-1:0] pool_ref(input logic [DW-1:0] v);
`ifdef POOL_CEIL_EN
    if (v[15:0] != 16'h0) return {v[19:16], 16'h0} + 20'h10000;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int base_l1, base_l2, base_strobe, err;
  logic [DW-1:0] expv;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      mem1[a] = DW'(a);
      mem2[a] = '0;
    end
    mem2[0] = 20'hFFFF0; mem2[1] = 20'h00010; mem2[64] = 20'h80000; mem2[65] = 20'h00010;
    mem2[2] = 20'h80000; mem2[3] = 20'hFFFFF; mem2[66] = 20'h80001; mem2[67] = 20'hFFFFE;
    mem2[4] = 20'h10001; mem2[5] = 20'h00000; mem2[68] = 20'h0FFFF; mem2[69] = 20'h00001;
    mem2[6] = 20'h30000; mem2[7] = 20'h2FFFF; mem2[70] = 20'h30000; mem2[71] = 20'h00000;

    // Reset held for three cycles
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_crd", crd, 1'b0);
    check("rst_cwr", cwr, 1'b0);
    check("rst_csel", csel, 3'd0);
    check("rst_caddr_rd", caddr_rd, 12'd0);
    check("rst_caddr_wr", caddr_wr, 12'd0);
    check("rst_cdata_wr", cdata_wr, 20'd0);
    reset = 1'b0;
    tick();

    // Run A: address pattern in K0, signed/rounding quads in K1
    start = 1'b1;
    ncyc = 0;
    tick();
    start = 1'b0;
    check("a_c1_crd", crd, 1'b1);
    check("a_c1_busy", busy, 1'b1);
    check("a_c1_csel", csel, 3'd1);
    check("a_rd0", caddr_rd, 12'd0);
    tick();
    check("a_rd1", caddr_rd, 12'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_rd2", caddr_rd, 12'd64);
    tick();
    check("a_rd3_after_ignored_start", caddr_rd, 12'd65);
    tick();
    check("a_cap_crd", crd, 1'b0);
    check("a_cap_cwr", cwr, 1'b0);
    tick();
    check("a_wl1_cwr", cwr, 1'b1);
    check("a_wl1_csel", csel, 3'd3);
    check("a_wl1_addr", caddr_wr, 12'd0);
    check("a_wl1_data", cdata_wr, pool_ref(20'd65));
    tick();
    check("a_wl2_csel", csel, 3'd5);
    check("a_wl2_addr", caddr_wr, 12'd0);
    check("a_wl2_data", cdata_wr, pool_ref(20'd65));
    tick();
    check("a_k1_csel", csel, 3'd2);
    check("a_k1_rd0", caddr_rd, 12'd0);
    while (!done && ncyc < 20000) tick();
    check("a_done_cycle", ncyc, 32'd14337);
    check("a_done_busy", busy, 1'b0);
    tick();
    check("a_after_done", done, 1'b0);
    check("a_idle_csel", csel, 3'd0);

    check("a_l1k0_0", mem3[0], pool_ref(20'd65));
    check("a_l1k0_1", mem3[1], pool_ref(20'd67));
    check("a_l1k0_32", mem3[32], pool_ref(20'd193));
    check("a_l1k0_1023", mem3[1023], pool_ref(20'd4095));
    check("a_l2_0", mem5[0], pool_ref(20'd65));
    check("a_signed_tie", mem4[0], pool_ref(20'h00010));
    check("a_signed_neg", mem4[1], pool_ref(20'hFFFFF));
    check("a_frac_up", mem4[2], pool_ref(20'h10001));
    check("a_frac_exact", mem4[3], pool_ref(20'h30000));
    check("a_l2_1", mem5[1], pool_ref(20'h00010));
    check("a_l2_3", mem5[3], pool_ref(20'hFFFFF));
    check("a_l2_7", mem5[7], pool_ref(20'h30000));
    check("a_l1_writes", l1_writes, 32'd2048);
    check("a_l2_writes", l2_writes, 32'd2048);

    // Run B: constant maps, verify the interleave
    for (int a = 0; a < 4096; a++) begin
      mem1[a] = 20'h11111;
      mem2[a] = 20'h22222;
    end
    base_l2 = l2_writes;
    start = 1'b1;
    ncyc = 0;
    tick();
    start = 1'b0;
    while (!done && ncyc < 20000) tick();
    check("b_done_cycle", ncyc, 32'd14337);
    tick();
    err = 0;
    for (int i = 0; i < 2048; i++) begin
      expv = i[0] ? pool_ref(20'h22222) : pool_ref(20'h11111);
      if (mem5[i] !== expv) err++;
    end
    check("b_l2_interleave", err, 32'd0);
    check("b_l2_2047", mem5[2047], pool_ref(20'h22222));
    check("b_l2_writes", l2_writes - base_l2, 32'd2048);
    check("b_l2_order", l2_order_err, 32'd0);
    check("b_bad_sel", bad_sel, 32'd0);

    // Run C: reset during the idx 5 read burst
    start = 1'b1;
    ncyc = 0;
    tick();
    start = 1'b0;
    while (!(crd && csel == 3'd1 && caddr_rd == 12'd10) && ncyc < 200) tick();
    check("c_reach_idx5", crd && caddr_rd == 12'd10, 1'b1);
    reset = 1'b1;
    #1;
    check("c_async_crd", crd, 1'b0);
    check("c_async_busy", busy, 1'b0);
    check("c_async_csel", csel, 3'd0);
    base_l1 = l1_writes;
    base_strobe = idle_strobe;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("c_no_writes", l1_writes - base_l1, 32'd0);
    check("c_no_strobes", idle_strobe - base_strobe, 32'd0);
    check("c_idle_busy", busy, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c_restart_rd0", caddr_rd, 12'd0);
    check("c_restart_csel", csel, 3'd1);
    repeat (5) tick();
    check("c_restart_wl1", cwr && caddr_wr == 12'd0 && csel == 3'd3, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    check("never_rd_and_wr", both_cnt, 32'd0);
    check("csel_zero_idle", idle_csel, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
